// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared definitions for the digit-serial adder.
//   state_e        - FSM state encoding (IDLE, RUN, DONE)
//   count_width()  - width of the digit counter for a given digit count
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One extra bit beyond $clog2 so the counter can hold N itself.
  function automatic int count_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple-carry adder built from
// per-bit full-adder cells.
//   a, b   - DIGIT-bit addends
//   cin    - carry into bit 0
//   s      - DIGIT-bit sum
//   cout   - carry out of the MSB
//   c_msb  - carry into the MSB (used for signed overflow detection)
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder computing {out_cout, out_sum} =
// in_a + in_b + in_cin, DIGIT bits per clock, least-significant digit first.
// A single digit_adder is reused for N = WIDTH/DIGIT cycles.
//   clk, rst_n           - clock (rising edge), async active-low reset
//   in_valid/in_ready    - operand handshake; in_ready is high only in IDLE
//   in_a, in_b, in_cin   - operands and carry-in, latched on accept
//   out_valid/out_ready  - result handshake; out_valid is high only in DONE
//   out_sum, out_cout    - result, held from DONE until the next DONE
// Optional feature macro SERIAL_ADDER_SUB_EN adds:
//   in_sub   - when 1 at accept, compute in_a - in_b (in_cin ignored)
//   out_ovf  - signed overflow of the final digit
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             in_sub,
  output logic             out_ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  if (WIDTH < 1) begin : g_bad_width
    $error("serial_adder: WIDTH must be >= 1");
  end
  if (DIGIT < 1) begin : g_bad_digit
    $error("serial_adder: DIGIT must be >= 1");
  end else if (WIDTH % DIGIT != 0) begin : g_bad_ratio
    $error("serial_adder: WIDTH must be a multiple of DIGIT");
  end

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = count_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_cout_q, res_cout_d;
`ifdef SERIAL_ADDER_SUB_EN
  logic             res_ovf_q, res_ovf_d;
`endif

  logic [DIGIT-1:0] dig_s;
  logic             dig_cout;
  logic             dig_c_msb;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .s     (dig_s),
    .cout  (dig_cout),
    .c_msb (dig_c_msb)
  );

  // The A register doubles as the sum shift register: as operand digits
  // leave the bottom, sum digits enter the top, so after N shifts it holds
  // the complete sum.
  if (DIGIT == WIDTH) begin : g_shift_full
    assign a_shift = dig_s;
  end else begin : g_shift_part
    assign a_shift = {dig_s, a_q[WIDTH-1:DIGIT]};
  end
  assign b_shift = b_q >> DIGIT;

`ifndef SERIAL_ADDER_SUB_EN
  logic unused_c_msb;
  assign unused_c_msb = dig_c_msb;
`endif

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    count_d    = count_q;
    res_sum_d  = res_sum_q;
    res_cout_d = res_cout_q;
`ifdef SERIAL_ADDER_SUB_EN
    res_ovf_d  = res_ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          count_d = '0;
          state_d = RUN;
`ifdef SERIAL_ADDER_SUB_EN
          // Subtraction as A + ~B + 1.
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub ? 1'b1 : in_cin;
`else
          b_d     = in_b;
          carry_d = in_cin;
`endif
        end
      end
      RUN: begin
        a_d     = a_shift;
        b_d     = b_shift;
        carry_d = dig_cout;
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d    = DONE;
          res_sum_d  = a_shift;
          res_cout_d = dig_cout;
`ifdef SERIAL_ADDER_SUB_EN
          res_ovf_d  = dig_c_msb ^ dig_cout;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      count_q    <= '0;
      res_sum_q  <= '0;
      res_cout_q <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      res_ovf_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      count_q    <= count_d;
      res_sum_q  <= res_sum_d;
      res_cout_q <= res_cout_d;
`ifdef SERIAL_ADDER_SUB_EN
      res_ovf_q  <= res_ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = res_sum_q;
  assign out_cout  = res_cout_q;
`ifdef SERIAL_ADDER_SUB_EN
  assign out_ovf   = res_ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder with WIDTH=8 at
// DIGIT = 1, 2, 4 and 8. Each instance gets the same directed vectors;
// the driver pushes hand-computed results into a queue and a monitor pops
// and compares them whenever the instance presents out_valid.
module tb_serial_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         acc_cyc;
    int         hold;
  } exp_t;

  logic clk;
  int   cyc;
  int   checks;
  int   errors;
  int   done_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int blk,
                             input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s (DIGIT=%0d): got %0h expected %0h", name, blk, act, expv);
    end
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int D = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 4 : 8;
    localparam int N = 8 / D;

    logic       rst_n, in_valid, in_ready, in_cin;
    logic       out_valid, out_ready, out_cout;
    logic [7:0] in_a, in_b, out_sum;
`ifdef SERIAL_ADDER_SUB_EN
    logic       in_sub, out_ovf;
`endif

    exp_t exp_q[$];
    exp_t cur;
    int   held;
    int   rel_cyc;
    bit   in_dn;
    bit   have_cur;

    serial_adder #(.WIDTH(8), .DIGIT(D)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
`ifdef SERIAL_ADDER_SUB_EN
      .in_sub    (in_sub),
      .out_ovf   (out_ovf),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout)
    );

    // Called at a negedge; returns at the negedge after the accept edge
    // (or one negedge later when keep_valid scrambles the operands).
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic sub,
                                 input logic [7:0] es, input logic ec, input logic eo,
                                 input int hold, input bit keep_valid,
                                 input bit chk_b2b, input bit push);
      logic rdy;
      bit   acc;
      int   acc_cyc;
      in_a = a;
      in_b = b;
      in_cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
      in_sub = sub;
`endif
      in_valid = 1'b1;
      acc = 0;
      for (int t = 0; t < 300 && !acc; t++) begin
        rdy = in_ready;
        @(posedge clk);
        @(negedge clk);
        if (rdy) acc = 1;
      end
      if (!acc) begin
        checkOutput("accept_timeout", D, 1, 0);
        in_valid = 1'b0;
        return;
      end
      acc_cyc = cyc;
      if (chk_b2b) checkOutput("b2b_accept_cycle", D, acc_cyc, rel_cyc + 2);
      if (push) exp_q.push_back('{es, ec, eo, acc_cyc, hold});
      if (keep_valid) begin
        in_a = ~a;
        in_b = 8'h5A;
        in_cin = ~cin;
`ifdef SERIAL_ADDER_SUB_EN
        in_sub = ~sub;
`endif
        @(negedge clk);
      end else begin
        in_valid = 1'b0;
      end
    endtask

    task automatic checkReset(input string tag);
      checkOutput({tag, "_in_ready"}, D, in_ready, 1);
      checkOutput({tag, "_out_valid"}, D, out_valid, 0);
      checkOutput({tag, "_out_sum"}, D, out_sum, 0);
      checkOutput({tag, "_out_cout"}, D, out_cout, 0);
`ifdef SERIAL_ADDER_SUB_EN
      checkOutput({tag, "_out_ovf"}, D, out_ovf, 0);
`endif
    endtask

    // Stimulus
    initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_a = 8'h00;
      in_b = 8'h00;
      in_cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      in_sub = 1'b0;
`endif
      @(negedge clk);
      checkReset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 0, 1);
      applyStimulus(8'h3C, 8'h45, 1'b1, 1'b0, 8'h82, 1'b0, 1'b1, 5, 0, 0, 1);

      // Operation abandoned by reset part-way through RUN.
      applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 0, 0);
      repeat ((N >= 4) ? 3 : 0) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkReset("midrun_reset");
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 0, 0, 0, 1);
      applyStimulus(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2, 1, 0, 1);
      applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 0, 0, 1, 1);
`ifdef SERIAL_ADDER_SUB_EN
      applyStimulus(8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 0, 0, 0, 1);
      applyStimulus(8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 0, 0, 0, 1);
`endif

      for (int t = 0; t < 300 && (exp_q.size() != 0 || out_valid); t++) @(negedge clk);
      if (exp_q.size() != 0 || out_valid) checkOutput("drain_timeout", D, 1, 0);
      done_cnt++;
    end

    // Monitor / consumer
    initial begin
      out_ready = 1'b0;
      in_dn = 0;
      have_cur = 0;
      held = 0;
      rel_cyc = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          in_dn = 0;
          out_ready = 1'b0;
        end else if (out_valid) begin
          if (!in_dn) begin
            in_dn = 1;
            held = 0;
            if (exp_q.size() == 0) begin
              have_cur = 0;
              checkOutput("spurious_valid", D, 1, 0);
            end else begin
              cur = exp_q.pop_front();
              have_cur = 1;
              checkOutput("latency", D, cyc - cur.acc_cyc, N);
              checkOutput("sum", D, out_sum, cur.sum);
              checkOutput("cout", D, out_cout, cur.cout);
`ifdef SERIAL_ADDER_SUB_EN
              checkOutput("ovf", D, out_ovf, cur.ovf);
`endif
            end
          end else begin
            held++;
            checkOutput("in_ready_in_done", D, in_ready, 0);
            if (have_cur) begin
              checkOutput("sum_stable", D, out_sum, cur.sum);
              checkOutput("cout_stable", D, out_cout, cur.cout);
            end
          end
          if (!have_cur || held >= cur.hold) begin
            out_ready = 1'b1;
            rel_cyc = cyc;
          end else begin
            out_ready = 1'b0;
          end
        end else begin
          if (in_dn && have_cur) begin
            checkOutput("in_ready_after_release", D, in_ready, 1);
            checkOutput("sum_kept_idle", D, out_sum, cur.sum);
          end
          in_dn = 0;
          out_ready = 1'b0;
        end
      end
    end
  end

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    done_cnt = 0;
    for (int t = 0; t < 20000 && done_cnt < 4; t++) @(negedge clk);
    if (done_cnt < 4) checkOutput("global_timeout", 0, done_cnt, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
